// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - accumulator sequencer: load/add/sub in one cycle, 4-cycle shift-add multiply
module alu_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             signal_run,
    input  logic [3:0]       sw,
    input  logic [3:0]       pb,
    output logic [WIDTH-1:0] acc,
    output logic             carry,
    output logic             zero,
    output logic             busy,
    output logic             done,
    output logic             overrun
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_MUL  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [1:0] OP_LOAD = 2'd0;
    localparam logic [1:0] OP_ADD  = 2'd1;
    localparam logic [1:0] OP_SUB  = 2'd2;
    localparam logic [1:0] OP_MUL  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             carry_q, carry_d;
    logic             zero_q, zero_d;
    logic             overrun_q, overrun_d;
    logic [1:0]       cnt_q, cnt_d;
    logic [WIDTH+3:0] prod_q, prod_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [3:0]       mplier_q, mplier_d;

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH+3:0] partial;
    logic [WIDTH+3:0] prod_sum;

    // pb[0] belongs to the upstream reset button and carries no opcode meaning here
    logic unused_pb0;
    assign unused_pb0 = pb[0];

    assign sum      = {1'b0, acc_q} + {1'b0, opnd_q};
    assign diff     = {1'b0, acc_q} - {1'b0, opnd_q};
    assign partial  = mplier_q[cnt_q] ? ({4'b0000, mcand_q} << cnt_q) : '0;
    assign prod_sum = prod_q + partial;

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        opnd_d    = opnd_q;
        acc_d     = acc_q;
        carry_d   = carry_q;
        zero_d    = zero_q;
        overrun_d = overrun_q;
        cnt_d     = cnt_q;
        prod_d    = prod_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;

        case (state_q)
            S_IDLE: begin
                if (signal_run) begin
                    opnd_d = WIDTH'(sw);
                    if (pb[3]) begin
                        op_d     = OP_MUL;
                        state_d  = S_MUL;
                        cnt_d    = 2'd0;
                        prod_d   = '0;
                        mcand_d  = acc_q;
                        mplier_d = sw;
                    end else begin
                        op_d    = pb[2] ? OP_SUB : (pb[1] ? OP_ADD : OP_LOAD);
                        state_d = S_EXEC;
                    end
                end
            end
            S_EXEC: begin
                case (op_q)
                    OP_ADD: begin
                        acc_d   = sum[WIDTH-1:0];
                        carry_d = sum[WIDTH];
                    end
                    OP_SUB: begin
                        acc_d   = diff[WIDTH-1:0];
                        carry_d = diff[WIDTH];
                    end
                    default: begin
                        acc_d   = opnd_q;
                        carry_d = 1'b0;
                    end
                endcase
                zero_d  = (acc_d == '0);
                state_d = S_DONE;
            end
            S_MUL: begin
                prod_d = prod_sum;
                cnt_d  = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    acc_d   = prod_sum[WIDTH-1:0];
                    carry_d = |prod_sum[WIDTH+3:WIDTH];
                    zero_d  = (prod_sum[WIDTH-1:0] == '0);
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (signal_run && (state_q != S_IDLE)) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            op_q      <= OP_LOAD;
            opnd_q    <= '0;
            acc_q     <= '0;
            carry_q   <= 1'b0;
            zero_q    <= 1'b0;
            overrun_q <= 1'b0;
            cnt_q     <= 2'd0;
            prod_q    <= '0;
            mcand_q   <= '0;
            mplier_q  <= 4'd0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            opnd_q    <= opnd_d;
            acc_q     <= acc_d;
            carry_q   <= carry_d;
            zero_q    <= zero_d;
            overrun_q <= overrun_d;
            cnt_q     <= cnt_d;
            prod_q    <= prod_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
        end
    end

    assign acc     = acc_q;
    assign carry   = carry_q;
    assign zero    = zero_q;
    assign overrun = overrun_q;
    assign busy    = (state_q == S_EXEC) || (state_q == S_MUL);
    assign done    = (state_q == S_DONE);

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - directed self-checking bench for alu_sequencer
module tb_alu_sequencer;

    logic       clk_in;
    logic       rst_n;
    logic       signal_run;
    logic [3:0] sw;
    logic [3:0] pb;
    logic [7:0] acc;
    logic       carry;
    logic       zero;
    logic       busy;
    logic       done;
    logic       overrun;

    int n_checks = 0;
    int n_pass   = 0;

    alu_sequencer #(.WIDTH(8)) dut (
        .clk_in     (clk_in),
        .rst_n      (rst_n),
        .signal_run (signal_run),
        .sw         (sw),
        .pb         (pb),
        .acc        (acc),
        .carry      (carry),
        .zero       (zero),
        .busy       (busy),
        .done       (done),
        .overrun    (overrun)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs === expv) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
    endtask

    task automatic check_res(input string tag, input int e_acc, input int e_carry, input int e_zero);
        check({tag, ".acc"}, 32'(acc), e_acc);
        check({tag, ".carry"}, 32'(carry), e_carry);
        check({tag, ".zero"}, 32'(zero), e_zero);
    endtask

    // Waits for done after a pulse; lat counts edges from the accepting edge.
    task automatic wait_done(input string tag, input int exp_lat);
        int lat;
        int busy_cycles;
        lat = 0;
        busy_cycles = 0;
        while (!done && lat < 20) begin
            if (busy) busy_cycles++;
            @(negedge clk_in);
            lat++;
        end
        check({tag, ".lat"}, lat, exp_lat);
        check({tag, ".busy_cycles"}, busy_cycles, exp_lat);
        check({tag, ".busy_in_done"}, 32'(busy), 0);
        @(negedge clk_in);
        check({tag, ".done_width"}, 32'(done), 0);
    endtask

    task automatic do_op(input string tag, input logic [3:0] s, input logic [3:0] p, input int exp_lat);
        @(negedge clk_in);
        signal_run = 1'b1;
        sw = s;
        pb = p;
        @(negedge clk_in);
        signal_run = 1'b0;
        sw = 4'hA;
        pb = 4'hF;
        wait_done(tag, exp_lat);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        signal_run = 1'b0;
        sw = 4'd0;
        pb = 4'd0;
        repeat (2) @(negedge clk_in);
        check_res("reset", 0, 0, 0);
        check("reset.busy", 32'(busy), 0);
        check("reset.done", 32'(done), 0);
        check("reset.overrun", 32'(overrun), 0);
        rst_n = 1'b1;

        do_op("load5", 4'd5, 4'b0000, 1);
        check_res("load5", 5, 0, 0);

        do_op("add3", 4'd3, 4'b0010, 1);
        check_res("add3", 8, 0, 0);

        do_op("ld15", 4'd15, 4'b0000, 1);
        do_op("mul15", 4'd15, 4'b1000, 4);
        check_res("225", 225, 0, 0);
        do_op("add15", 4'd15, 4'b0010, 1);
        do_op("add10", 4'd10, 4'b0010, 1);
        check_res("250", 250, 0, 0);
        do_op("add9", 4'd9, 4'b0010, 1);
        check_res("add9", 3, 1, 0);

        do_op("sub4", 4'd4, 4'b0100, 1);
        check_res("sub4", 255, 1, 0);
        do_op("ld3", 4'd3, 4'b0000, 1);
        do_op("sub3", 4'd3, 4'b0110, 1);
        check_res("sub3", 0, 0, 1);

        do_op("ld13", 4'd13, 4'b0001, 1);
        check_res("ld13_pb0", 13, 0, 0);
        do_op("mul11", 4'd11, 4'b1000, 4);
        check_res("mul11", 143, 0, 0);

        do_op("ld10", 4'd10, 4'b0000, 1);
        do_op("mul10", 4'd10, 4'b1000, 4);
        check_res("100", 100, 0, 0);
        do_op("mul15b", 4'd15, 4'b1000, 4);
        check_res("mul15b", 220, 1, 0);

        do_op("ld6", 4'd6, 4'b0000, 1);
        do_op("mulprio", 4'd7, 4'b1010, 4);
        check_res("mulprio", 42, 0, 0);
        do_op("zeromul", 4'd0, 4'b1000, 4);
        check_res("zeromul", 0, 0, 1);
        do_op("ld9", 4'd9, 4'b0011, 1);
        check_res("add_pb0", 9, 0, 0);
        check("pre_overrun", 32'(overrun), 0);

        repeat (3) @(negedge clk_in);
        check_res("hold", 9, 0, 0);

        // overrun: second pulse lands while the multiply is in flight
        do_op("ld13b", 4'd13, 4'b0000, 1);
        @(negedge clk_in);
        signal_run = 1'b1; sw = 4'd11; pb = 4'b1000;
        @(negedge clk_in);
        signal_run = 1'b0;
        check("ovr.busy", 32'(busy), 1);
        @(negedge clk_in);
        signal_run = 1'b1; sw = 4'd15; pb = 4'b0000;
        @(negedge clk_in);
        signal_run = 1'b0;
        check("ovr.flag", 32'(overrun), 1);
        check("ovr.acc_mid", 32'(acc), 13);
        wait_done("ovr", 2);
        check_res("ovr", 143, 0, 0);
        do_op("ld2", 4'd2, 4'b0000, 1);
        check_res("ld2", 2, 0, 0);
        check("ovr.sticky", 32'(overrun), 1);

        // reset two cycles into a multiply
        @(negedge clk_in);
        signal_run = 1'b1; sw = 4'd11; pb = 4'b1000;
        @(negedge clk_in);
        signal_run = 1'b0;
        repeat (2) @(negedge clk_in);
        #2 rst_n = 1'b0;
        #1;
        check_res("arst", 0, 0, 0);
        check("arst.busy", 32'(busy), 0);
        check("arst.done", 32'(done), 0);
        check("arst.overrun", 32'(overrun), 0);
        repeat (4) begin
            @(negedge clk_in);
            check("arst.no_done", 32'(done), 0);
        end
        rst_n = 1'b1;
        do_op("ld7", 4'd7, 4'b0000, 1);
        check_res("ld7", 7, 0, 0);
        check("ld7.overrun", 32'(overrun), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
